// File: rtl/sdram_pkg.sv
// Shared widths and port-select types for the SDRAM port arbiter.
package sdram_pkg;

   localparam int SDRAM_ADDR_W = 32;
   localparam int SDRAM_DATA_W = 32;
   localparam int SDRAM_BE_W   = SDRAM_DATA_W / 8;

   typedef enum logic {PORT_A, PORT_B} port_id_t;

   typedef struct packed {
      logic     valid;
      port_id_t id;
   } port_sel_t;

endpackage

// File: rtl/sdram_port_arb.sv
// Two-port fixed-priority arbiter (A over B) in front of the SDRAM core; zero-latency request pass-through.
// Backpressure: a request holds until the core accepts; all requests stall while one read is outstanding.
module sdram_port_arb
   import sdram_pkg::*;
#(
   parameter int ADDR_W = SDRAM_ADDR_W,
   parameter int DATA_W = SDRAM_DATA_W,
   parameter int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_write_data,
   input  logic [BE_W-1:0]   a_wr,
   input  logic              a_rd,
   output logic              a_accept,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_read_data,

   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_write_data,
   input  logic [BE_W-1:0]   b_wr,
   input  logic              b_rd,
   output logic              b_accept,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_read_data,

   output logic [ADDR_W-1:0] c_addr,
   output logic [DATA_W-1:0] c_write_data,
   output logic [BE_W-1:0]   c_wr,
   output logic              c_rd,
   input  logic              c_accept,
   input  logic              c_ack,
   input  logic [DATA_W-1:0] c_read_data
);

   port_sel_t lock_sel;
   port_sel_t rd_owner;
   port_sel_t sel;
   logic      req_a;
   logic      req_b;
   logic      sel_req;
   logic      sel_a;
   logic      sel_b;

   assign req_a = (a_wr != '0) | a_rd;
   assign req_b = (b_wr != '0) | b_rd;

   // An outstanding read blocks everything; a lock keeps a presented request on the core until accepted.
   always_comb begin
      sel = '{valid: 1'b0, id: PORT_A};
      if (rd_owner.valid) begin
         sel = '{valid: 1'b0, id: PORT_A};
      end else if (lock_sel.valid) begin
         sel = lock_sel;
      end else if (req_a) begin
         sel = '{valid: 1'b1, id: PORT_A};
      end else if (req_b) begin
         sel = '{valid: 1'b1, id: PORT_B};
      end
   end

   assign sel_a   = sel.valid & (sel.id == PORT_A);
   assign sel_b   = sel.valid & (sel.id == PORT_B);
   assign sel_req = (sel_a & req_a) | (sel_b & req_b);

   always_comb begin
      c_addr       = '0;
      c_write_data = '0;
      c_wr         = '0;
      c_rd         = 1'b0;
      if (!rst && sel_a) begin
         c_addr       = a_addr;
         c_write_data = a_write_data;
         c_wr         = a_wr;
         c_rd         = a_rd;
      end else if (!rst && sel_b) begin
         c_addr       = b_addr;
         c_write_data = b_write_data;
         c_wr         = b_wr;
         c_rd         = b_rd;
      end
   end

   assign a_accept = c_accept & sel_a & req_a;
   assign b_accept = c_accept & sel_b & req_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_sel <= '{valid: 1'b0, id: PORT_A};
      end else if (c_accept) begin
         lock_sel <= '{valid: 1'b0, id: PORT_A};
      end else if (sel_req) begin
         lock_sel <= sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_owner <= '{valid: 1'b0, id: PORT_A};
      end else if (c_accept && c_rd) begin
         rd_owner <= sel;
      end else if (c_ack && rd_owner.valid) begin
         rd_owner <= '{valid: 1'b0, id: PORT_A};
      end
   end

   // An ack with no tracked owner (e.g. a read in flight across reset) is dropped.
   assign a_ack = !rst & c_ack & rd_owner.valid & (rd_owner.id == PORT_A);
   assign b_ack = !rst & c_ack & rd_owner.valid & (rd_owner.id == PORT_B);

   assign a_read_data = c_read_data;
   assign b_read_data = c_read_data;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench: drives both ports and the core side by hand and checks routing, locking and read tracking.
module tb_sdram_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_addr, a_write_data, a_read_data;
   logic [3:0]  a_wr;
   logic        a_rd, a_accept, a_ack;
   logic [31:0] b_addr, b_write_data, b_read_data;
   logic [3:0]  b_wr;
   logic        b_rd, b_accept, b_ack;
   logic [31:0] c_addr, c_write_data, c_read_data;
   logic [3:0]  c_wr;
   logic        c_rd, c_accept, c_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdram_port_arb dut (
      .clk(clk), .rst(rst),
      .a_addr(a_addr), .a_write_data(a_write_data), .a_wr(a_wr), .a_rd(a_rd),
      .a_accept(a_accept), .a_ack(a_ack), .a_read_data(a_read_data),
      .b_addr(b_addr), .b_write_data(b_write_data), .b_wr(b_wr), .b_rd(b_rd),
      .b_accept(b_accept), .b_ack(b_ack), .b_read_data(b_read_data),
      .c_addr(c_addr), .c_write_data(c_write_data), .c_wr(c_wr), .c_rd(c_rd),
      .c_accept(c_accept), .c_ack(c_ack), .c_read_data(c_read_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_addr = '0; a_write_data = '0; a_wr = '0; a_rd = 1'b0;
      b_addr = '0; b_write_data = '0; b_wr = '0; b_rd = 1'b0;
      c_accept = 1'b0; c_ack = 1'b0; c_read_data = '0;
      step(); step();
      #1;
      checks++;
      if ({c_rd, c_wr, a_accept, b_accept, a_ack, b_ack} !== 9'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b exp 0", {c_rd, c_wr, a_accept, b_accept, a_ack, b_ack});
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_a_write();
      a_addr = 32'h0000_1000; a_write_data = 32'hDEAD_BEEF; a_wr = 4'hF;
      #1;
      checks++;
      if ({c_addr, c_write_data, c_wr, c_rd} !== {32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
         errors++;
         $display("FAIL a_write_mirror got %h %h %h %b exp 00001000 deadbeef f 0", c_addr, c_write_data, c_wr, c_rd);
      end
      checks++;
      if (a_accept !== 1'b0) begin
         errors++;
         $display("FAIL a_write_early_accept got %b exp 0", a_accept);
      end
      step(); step();
      c_accept = 1'b1;
      #1;
      checks++;
      if ({a_accept, b_accept} !== 2'b10) begin
         errors++;
         $display("FAIL a_write_accept got a=%b b=%b exp a=1 b=0", a_accept, b_accept);
      end
      step();
      a_wr = '0; c_accept = 1'b0;
      #1;
      checks++;
      if ({c_wr, c_rd} !== 5'b0) begin
         errors++;
         $display("FAIL a_write_idle got wr=%h rd=%b exp 0", c_wr, c_rd);
      end
   endtask

   task automatic test_a_read();
      a_addr = 32'h0000_1000; a_rd = 1'b1;
      #1;
      checks++;
      if ({c_rd, c_addr} !== {1'b1, 32'h0000_1000}) begin
         errors++;
         $display("FAIL a_read_fwd got rd=%b addr=%h exp 1 00001000", c_rd, c_addr);
      end
      c_accept = 1'b1;
      #1;
      checks++;
      if (a_accept !== 1'b1) begin
         errors++;
         $display("FAIL a_read_accept got %b exp 1", a_accept);
      end
      step();
      a_rd = 1'b0; c_accept = 1'b0;
      b_addr = 32'h0000_3000; b_rd = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({c_rd, c_wr} !== 5'b0) begin
            errors++;
            $display("FAIL a_read_stall cycle %0d got rd=%b wr=%h exp 0", i, c_rd, c_wr);
         end
         step();
      end
      c_ack = 1'b1; c_read_data = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({a_ack, b_ack, a_read_data} !== {2'b10, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL a_read_ack got a=%b b=%b data=%h exp 1 0 deadbeef", a_ack, b_ack, a_read_data);
      end
      checks++;
      if (c_rd !== 1'b0) begin
         errors++;
         $display("FAIL ack_cycle_stall got rd=%b exp 0", c_rd);
      end
      step();
      c_ack = 1'b0;
      #1;
      checks++;
      if ({c_rd, c_addr} !== {1'b1, 32'h0000_3000}) begin
         errors++;
         $display("FAIL b_read_fwd got rd=%b addr=%h exp 1 00003000", c_rd, c_addr);
      end
      c_accept = 1'b1;
      #1;
      checks++;
      if ({a_accept, b_accept} !== 2'b01) begin
         errors++;
         $display("FAIL b_read_accept got a=%b b=%b exp a=0 b=1", a_accept, b_accept);
      end
      step();
      b_rd = 1'b0; c_accept = 1'b0;
      step();
      c_ack = 1'b1; c_read_data = 32'h0BAD_F00D;
      #1;
      checks++;
      if ({a_ack, b_ack, b_read_data} !== {2'b01, 32'h0BAD_F00D}) begin
         errors++;
         $display("FAIL b_read_ack got a=%b b=%b data=%h exp 0 1 0badf00d", a_ack, b_ack, b_read_data);
      end
      step();
      c_ack = 1'b0;
   endtask

   task automatic test_simultaneous();
      a_addr = 32'h10; a_write_data = 32'h1111_1111; a_wr = 4'hF;
      b_addr = 32'h20; b_write_data = 32'h2222_2222; b_wr = 4'hF;
      #1;
      checks++;
      if ({c_addr, c_write_data} !== {32'h10, 32'h1111_1111}) begin
         errors++;
         $display("FAIL sim_a_first got %h %h exp 00000010 11111111", c_addr, c_write_data);
      end
      c_accept = 1'b1;
      #1;
      checks++;
      if ({a_accept, b_accept} !== 2'b10) begin
         errors++;
         $display("FAIL sim_a_accept got a=%b b=%b exp a=1 b=0", a_accept, b_accept);
      end
      step();
      a_wr = '0; c_accept = 1'b0;
      #1;
      checks++;
      if ({c_addr, c_write_data, c_wr} !== {32'h20, 32'h2222_2222, 4'hF}) begin
         errors++;
         $display("FAIL sim_b_next got %h %h %h exp 00000020 22222222 f", c_addr, c_write_data, c_wr);
      end
      c_accept = 1'b1;
      #1;
      checks++;
      if ({a_accept, b_accept} !== 2'b01) begin
         errors++;
         $display("FAIL sim_b_accept got a=%b b=%b exp a=0 b=1", a_accept, b_accept);
      end
      step();
      b_wr = '0; c_accept = 1'b0;
   endtask

   task automatic test_lock();
      b_addr = 32'h40; b_write_data = 32'h4444_4444; b_wr = 4'h3;
      #1;
      checks++;
      if ({c_addr, c_wr} !== {32'h40, 4'h3}) begin
         errors++;
         $display("FAIL lock_b_present got %h %h exp 00000040 3", c_addr, c_wr);
      end
      step();
      a_addr = 32'h50; a_write_data = 32'h5555_5555; a_wr = 4'hC;
      for (int i = 1; i < 3; i++) begin
         #1;
         checks++;
         if ({c_addr, c_wr, a_accept} !== {32'h40, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL lock_hold cycle %0d got %h %h acc=%b exp 00000040 3 0", i, c_addr, c_wr, a_accept);
         end
         step();
      end
      c_accept = 1'b1;
      #1;
      checks++;
      if ({c_addr, a_accept, b_accept} !== {32'h40, 2'b01}) begin
         errors++;
         $display("FAIL lock_b_accept got %h a=%b b=%b exp 00000040 0 1", c_addr, a_accept, b_accept);
      end
      step();
      b_wr = '0; c_accept = 1'b0;
      #1;
      checks++;
      if ({c_addr, c_write_data, c_wr} !== {32'h50, 32'h5555_5555, 4'hC}) begin
         errors++;
         $display("FAIL lock_a_next got %h %h %h exp 00000050 55555555 c", c_addr, c_write_data, c_wr);
      end
      c_accept = 1'b1;
      #1;
      checks++;
      if ({a_accept, b_accept} !== 2'b10) begin
         errors++;
         $display("FAIL lock_a_accept got a=%b b=%b exp a=1 b=0", a_accept, b_accept);
      end
      step();
      a_wr = '0; c_accept = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      a_addr = 32'h60; a_rd = 1'b1; c_accept = 1'b1;
      #1;
      checks++;
      if (a_accept !== 1'b1) begin
         errors++;
         $display("FAIL rst_read_accept got %b exp 1", a_accept);
      end
      step();
      a_rd = 1'b0; c_accept = 1'b0;
      rst = 1'b1; b_addr = 32'h70; b_wr = 4'hF;
      #1;
      checks++;
      if ({c_rd, c_wr} !== 5'b0) begin
         errors++;
         $display("FAIL rst_core_idle got rd=%b wr=%h exp 0", c_rd, c_wr);
      end
      step();
      rst = 1'b0; b_wr = '0;
      c_ack = 1'b1; c_read_data = 32'h1234_5678;
      #1;
      checks++;
      if ({a_ack, b_ack} !== 2'b00) begin
         errors++;
         $display("FAIL rst_stale_ack got a=%b b=%b exp 0 0", a_ack, b_ack);
      end
      step();
      c_ack = 1'b0; b_wr = 4'hF;
      #1;
      checks++;
      if ({c_wr, c_addr} !== {4'hF, 32'h70}) begin
         errors++;
         $display("FAIL rst_no_stall got wr=%h addr=%h exp f 00000070", c_wr, c_addr);
      end
      c_accept = 1'b1;
      step();
      b_wr = '0; c_accept = 1'b0;
   endtask

   initial begin
      test_reset();
      test_a_write();
      test_a_read();
      test_simultaneous();
      test_lock();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
